// File: rtl/tdm_mux_scan.sv
// rtl/tdm_mux_scan.sv - registered N:1 TDM mux with manual select and auto-scan
// Optional channel mask: define TDM_MUX_CHMASK_EN to add the ch_mask port.
module tdm_mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
`ifdef TDM_MUX_CHMASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          data_out,
  output logic [SELW-1:0]           ch_out,
  output logic                      valid,
  output logic                      frame_start
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CHANNELS-1:0] mask;
`ifdef TDM_MUX_CHMASK_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;

  logic [SELW-1:0]  eff_ptr, first_en;
  logic [CW-1:0]    eff_cnt;
  logic             any_en;

  function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0] idx,
                                            input logic [CHANNELS*WIDTH-1:0] din);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(idx) == k) r = din[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // First enabled channel strictly after p, wrapping; returns p when nothing else is enabled.
  function automatic logic [SELW-1:0] next_en(input logic [SELW-1:0] p,
                                              input logic [CHANNELS-1:0] m);
    logic [SELW-1:0] r;
    logic            found;
    int              idx;
    r = p;
    found = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(p) + i) % CHANNELS;
      if (!found && m[idx]) begin
        r = SELW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // A masked pointer is replaced by the next enabled channel with a fresh dwell.
  always_comb begin
    any_en   = |mask;
    first_en = next_en(SELW'(CHANNELS - 1), mask);
    if (mask[ptr_q]) begin
      eff_ptr = ptr_q;
      eff_cnt = cnt_q;
    end else begin
      eff_ptr = next_en(ptr_q, mask);
      eff_cnt = '0;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    fs_d    = 1'b0;
    if (en) begin
      if (!mode) begin
        ptr_d = '0;
        cnt_d = '0;
        ch_d  = sel;
        if (int'(sel) < CHANNELS && mask[sel]) begin
          data_d  = pick(sel, data_in);
          valid_d = 1'b1;
        end else begin
          data_d = '0;
        end
      end else if (!any_en) begin
        data_d = '0;
        ch_d   = ptr_q;
      end else begin
        data_d  = pick(eff_ptr, data_in);
        ch_d    = eff_ptr;
        valid_d = 1'b1;
        fs_d    = (eff_ptr == first_en) && (eff_cnt == '0);
        if (eff_cnt == CNT_LAST) begin
          cnt_d = '0;
          ptr_d = next_en(eff_ptr, mask);
        end else begin
          cnt_d = eff_cnt + 1'b1;
          ptr_d = eff_ptr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
    end
  end

  assign data_out    = data_q;
  assign ch_out      = ch_q;
  assign valid       = valid_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_tdm_mux_scan.sv
// tb/tb_tdm_mux_scan.sv - table-driven scoreboard bench for tdm_mux_scan
module tb_tdm_mux_scan;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int DWELL    = 4;
  localparam int SELW     = 2;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam logic [31:0] DATA = {8'hD4, 8'hC3, 8'hB2, 8'hA1};

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [7:0]  e_data;
    logic [1:0]  e_ch;
    logic        e_valid;
    logic        e_fs;
    string       name;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n, en, mode;
  logic [SELW-1:0]  sel;
  logic [31:0]      data_in;
  logic [CHANNELS-1:0] ch_mask = '1;
  logic [WIDTH-1:0] data_out;
  logic [SELW-1:0]  ch_out;
  logic             valid, frame_start;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic done = 1'b0;

  tdm_mux_scan #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .data_in(data_in),
`ifdef TDM_MUX_CHMASK_EN
    .ch_mask(ch_mask),
`endif
    .data_out(data_out), .ch_out(ch_out), .valid(valid), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (TIMEOUT_CYCLES) @(posedge clk);
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete within %0d cycles", TIMEOUT_CYCLES);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic add(input logic r, input logic e, input logic m, input logic [1:0] s,
                     input logic [31:0] d, input logic [7:0] ed, input logic [1:0] ec,
                     input logic ev, input logic efs, input string nm);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.sel = s; v.din = d;
    v.e_data = ed; v.e_ch = ec; v.e_valid = ev; v.e_fs = efs; v.name = nm;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] chan(input logic [31:0] d, input int k);
    return d[k*8 +: 8];
  endfunction

  initial begin
    vec_t e;
    logic [31:0] rd;
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = '0; data_in = '0;

    add(0, 1, 1, 0, 32'($urandom), 8'h00, 0, 0, 0, "reset0");
    add(0, 0, 1, 3, 32'($urandom), 8'h00, 0, 0, 0, "reset1");
    add(1, 1, 0, 2, DATA, 8'hC3, 2, 1, 0, "manual_sel2");
    add(1, 1, 0, 0, DATA, 8'hA1, 0, 1, 0, "manual_sel0");
    for (int k = 1; k <= 20; k++)
      add(1, 1, 1, 0, DATA, chan(DATA, ((k - 1) / 4) % 4), 2'(((k - 1) / 4) % 4), 1,
          (k == 1 || k == 17), "auto_wrap");
    add(1, 1, 1, 0, DATA, 8'hB2, 1, 1, 0, "pre_freeze");
    add(1, 1, 1, 0, DATA, 8'hB2, 1, 1, 0, "pre_freeze");
    for (int k = 0; k < 3; k++)
      add(1, 0, 1, 0, DATA, 8'hB2, 1, 0, 0, "freeze");
    add(1, 1, 1, 0, DATA, 8'hB2, 1, 1, 0, "resume");
    add(1, 1, 1, 0, DATA, 8'hB2, 1, 1, 0, "resume");
    for (int k = 0; k < 4; k++)
      add(1, 1, 1, 0, DATA, 8'hC3, 2, 1, 0, "after_freeze");
    add(1, 1, 1, 1, DATA, 8'hD4, 3, 1, 0, "ch3");
    add(1, 1, 1, 1, DATA, 8'hD4, 3, 1, 0, "ch3");
    add(1, 1, 0, 1, DATA, 8'hB2, 1, 1, 0, "to_manual");
    add(1, 1, 1, 1, DATA, 8'hA1, 0, 1, 1, "to_auto");
    for (int k = 0; k < 3; k++)
      add(1, 1, 1, 0, DATA, 8'hA1, 0, 1, 0, "auto_ch0");
    for (int k = 0; k < 4; k++)
      add(1, 1, 1, 0, DATA, 8'hB2, 1, 1, 0, "auto_ch1");
    add(1, 1, 1, 0, DATA, 8'hC3, 2, 1, 0, "auto_ch2");
    add(0, 1, 1, 0, DATA, 8'h00, 0, 0, 0, "mid_reset");
    for (int k = 0; k < 8; k++) begin
      rd = 32'($urandom);
      add(1, 1, 1, 0, rd, chan(rd, k / 4), 2'(k / 4), 1, (k == 0), "post_reset_track");
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; en = vecs[i].en; mode = vecs[i].mode;
      sel = vecs[i].sel; data_in = vecs[i].din;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (data_out !== e.e_data || ch_out !== e.e_ch || valid !== e.e_valid ||
          frame_start !== e.e_fs) begin
        errors++;
        $display("FAIL %s vec %0d: got data=%h ch=%0d valid=%b fs=%b, want data=%h ch=%0d valid=%b fs=%b",
                 e.name, i, data_out, ch_out, valid, frame_start,
                 e.e_data, e.e_ch, e.e_valid, e.e_fs);
      end
      if (!e.rst_n) begin
        checks++;
        if (data_out !== '0 || ch_out !== '0 || valid !== 1'b0 || frame_start !== 1'b0) begin
          errors++;
          $display("FAIL reset-state vec %0d: data=%h ch=%0d valid=%b fs=%b not at reset values",
                   i, data_out, ch_out, valid, frame_start);
        end
      end
    end

    done = 1'b1;
    if (checks < vecs.size()) begin
      errors++;
      $display("FAIL check count: %0d checks for %0d vectors", checks, vecs.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_mux_scan.md
Name: tdm_mux_scan

Overview:
- Parametrised, registered N:1 multiplexer; successor to the combinational 2:1 mux.
- Two modes:
  - Manual: an external select picks the channel.
  - Auto-scan: an internal channel pointer steps through all channels, dwelling DWELL cycles on each.
- Used as a time-division front end feeding a single-lane consumer (display, serializer, monitor).

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 4, number of input channels (>=2).
- DWELL, 4, cycles spent on each channel in auto-scan (>=1).
- SELW, derived as $clog2(CHANNELS), select/pointer width; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  global enable; low freezes all state.
- mode  in  1  0 = manual, 1 = auto-scan.
- sel  in  SELW  channel select used in manual mode.
- data_in  in  CHANNELS*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- data_out  out  WIDTH  registered selected data.
- ch_out  out  SELW  index of the channel currently presented on data_out.
- valid  out  1  data_out holds a legitimately selected channel.
- frame_start  out  1  one-cycle pulse marking the first auto-scan cycle on channel 0.

Behaviour:
- Reset: sampled on rising clk while rst_n=0; it overrides en. data_out=0, ch_out=0, valid=0, frame_start=0, pointer=0, dwell counter=0.
- All outputs are registered. Latency is 1 cycle from a data_in/sel change to data_out.
- en=0: pointer, counter and data_out hold; valid=0; frame_start=0. When en rises, operation resumes from the held state; the counter is not cleared.
- Manual mode (mode=0, en=1):
  - data_out <= channel sel; ch_out <= sel; valid <= 1.
  - sel >= CHANNELS (non-power-of-2 CHANNELS only): data_out <= 0, ch_out <= sel, valid <= 0.
  - Pointer and counter are held at 0 while in manual mode.
  - frame_start=0.
- Auto-scan (mode=1, en=1):
  - Each cycle: data_out <= channel[pointer]; ch_out <= pointer; valid <= 1.
  - Counter increments each cycle.
  - When counter == DWELL-1: counter -> 0 and pointer -> pointer+1. When pointer == CHANNELS-1, it wraps to 0.
  - frame_start <= 1 only in the cycle where pointer==0 and counter==0; otherwise 0.
  - DWELL=1: pointer advances every cycle; frame_start fires once per CHANNELS cycles.
  - data_in changes during a dwell are tracked every cycle; there is no latching per dwell.
- Mode change 0->1: the scan starts at pointer 0, counter 0, so frame_start fires in the first auto cycle.
- Mode change 1->0: the pointer and counter clear to 0 on that edge, and manual select applies the same cycle.
- Reset asserted mid-scan: everything returns to reset values on that edge. The first cycle after release with mode=1, en=1 is a frame_start cycle.
- Counter width is $clog2(DWELL)+1; it must not overflow for any legal DWELL.

Optional Feature:
- Macro: TDM_MUX_CHMASK_EN.
- Defined:
  - Adds input port ch_mask (CHANNELS bits, 1 = channel enabled).
  - Auto-scan skips masked channels: on advance, the pointer moves to the next enabled index (wrapping).
  - If the current channel becomes masked mid-dwell, the pointer advances on the next cycle and the counter resets.
  - All channels masked: pointer holds, valid=0, data_out=0.
  - frame_start fires on the first dwell cycle of the lowest enabled index.
  - Manual select of a masked channel gives valid=0, data_out=0.
- Undefined: no ch_mask port; all channels are always enabled; behaviour is exactly as above.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random data_in, mode=1 -> data_out=0, ch_out=0, valid=0, frame_start=0 on every sampled edge.
- Manual: WIDTH=8, CHANNELS=4, data_in={8'hD4,8'hC3,8'hB2,8'hA1}, mode=0, sel=2 -> data_out=8'hC3, ch_out=2, valid=1 one cycle later; then sel=0 -> 8'hA1 next cycle.
- Auto wrap: same data_in, DWELL=4, mode=1 for 20 cycles:
  - A1 appears for cycles 1-4, B2 for 5-8, C3 for 9-12, D4 for 13-16, A1 again from cycle 17.
  - frame_start=1 only at cycles 1 and 17.
- Freeze: en=0 for 3 cycles at counter=2 on channel 1 -> outputs hold, valid=0. After en=1, channel 1 remains for 2 more cycles, then channel 2.
- Mode switch and mid-scan reset:
  - Mode 1->0 mid-dwell on channel 3, with sel=1 -> next cycle data_out=8'hB2.
  - Then mode 0->1 -> channel 0 with frame_start=1.
  - rst_n=0 during channel 2 -> reset values; after release, scan resumes at channel 0.
- With TDM_MUX_CHMASK_EN: ch_mask=4'b1010, DWELL=2 -> sequence B2,B2,D4,D4,B2..., with frame_start on the first B2. Then ch_mask=0 -> valid=0, data_out=0.
